// File: rtl/mod_seq_ctrl_pkg.sv
// Shared types for the repeated-subtraction mod/divide sequencer: state encoding,
// command bundle and the state-to-command decode.
package mod_seq_ctrl_pkg;

  localparam int CNT_W_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_CMP  = 3'd2,
    ST_SUB  = 3'd3,
    ST_SAVE = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  typedef struct packed {
    logic load;
    logic cmp;
    logic sub;
    logic save;
  } cmd_t;

  // One-hot datapath command per working state; none in IDLE/DONE or illegal codes.
  function automatic cmd_t decode_cmd(input state_e s);
    cmd_t c;
    c      = '0;
    c.load = (s == ST_LOAD);
    c.cmp  = (s == ST_CMP);
    c.sub  = (s == ST_SUB);
    c.save = (s == ST_SAVE);
    return c;
  endfunction

endpackage

// File: rtl/mod_seq_ctrl_if.sv
// Handshake/command bundle between the ALU decoder + mod datapath (master) and
// the sequencer (slave).
interface mod_seq_ctrl_if
  import mod_seq_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic             start;
  logic             abort;
  logic             divisor_zero;
  logic             temp_less_than;
  logic             load_command;
  logic             compare_command;
  logic             substract_command;
  logic             save_command;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] quotient;
  logic             div_by_zero;
  logic             limit_err;

  modport master (
    output start, abort, divisor_zero, temp_less_than,
    input  load_command, compare_command, substract_command, save_command,
           busy, done, quotient, div_by_zero, limit_err
  );

  modport slave (
    input  start, abort, divisor_zero, temp_less_than,
    output load_command, compare_command, substract_command, save_command,
           busy, done, quotient, div_by_zero, limit_err
  );
endinterface

// File: rtl/mod_iter_counter.sv
// Iteration/quotient up-counter with a registered-count compare against MAX_ITER.
// at_limit is high when the next increment would reach MAX_ITER.
module mod_iter_counter #(
  parameter int               CNT_W    = 32,
  parameter logic [CNT_W-1:0] MAX_ITER = {CNT_W{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             at_limit
);

  localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LAST = MAX_ITER - ONE;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count    = count_q;
  assign at_limit = (count_q == LAST);

endmodule

// File: rtl/mod_seq_ctrl.sv
// Sequencer for the 32-bit repeated-subtraction modulo/divide datapath: issues
// load/compare/subtract/save, counts subtractions, reports done and error flags.
module mod_seq_ctrl
  import mod_seq_ctrl_pkg::*;
#(
  parameter int               CNT_W    = CNT_W_DEF,
  parameter logic [CNT_W-1:0] MAX_ITER = {CNT_W{1'b1}}
) (
  input  logic          clk,
  input  logic          rst,
  mod_seq_ctrl_if.slave bus
);

  state_e           state_q, state_d;
  logic             dbz_q, dbz_d;
  logic             lim_q, lim_d;
  logic             cnt_clear, cnt_inc;
  logic             at_limit;
  logic [CNT_W-1:0] count;
  cmd_t             cmd;

  mod_iter_counter #(
    .CNT_W    (CNT_W),
    .MAX_ITER (MAX_ITER)
  ) u_iter_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    (cnt_clear),
    .inc      (cnt_inc),
    .count    (count),
    .at_limit (at_limit)
  );

  always_comb begin
    state_d   = state_q;
    dbz_d     = dbz_q;
    lim_d     = lim_q;
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_LOAD;
          dbz_d   = 1'b0;
          lim_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        cnt_clear = 1'b1;
        if (bus.divisor_zero) begin
          state_d = ST_DONE;
          dbz_d   = 1'b1;
        end else begin
          state_d = ST_CMP;
        end
      end
      ST_CMP: begin
        state_d = bus.temp_less_than ? ST_SAVE : ST_SUB;
      end
      ST_SUB: begin
        cnt_inc = 1'b1;
        if (at_limit) begin
          state_d = ST_DONE;
          lim_d   = 1'b1;
        end else begin
          state_d = ST_CMP;
        end
      end
      ST_SAVE: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over everything and leaves the partial quotient and flags untouched.
    if (bus.abort && (state_q inside {ST_LOAD, ST_CMP, ST_SUB, ST_SAVE})) begin
      state_d   = ST_IDLE;
      dbz_d     = dbz_q;
      lim_d     = lim_q;
      cnt_clear = 1'b0;
      cnt_inc   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      dbz_q   <= 1'b0;
      lim_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dbz_q   <= dbz_d;
      lim_q   <= lim_d;
    end
  end

  assign cmd                   = decode_cmd(state_q);
  assign bus.load_command      = cmd.load;
  assign bus.compare_command   = cmd.cmp;
  assign bus.substract_command = cmd.sub;
  assign bus.save_command      = cmd.save;
  assign bus.busy              = (state_q != ST_IDLE);
  assign bus.done              = (state_q == ST_DONE);
  assign bus.quotient          = count;
  assign bus.div_by_zero       = dbz_q;
  assign bus.limit_err         = lim_q;

endmodule
